// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared state codes, handshake constants, EX aluop codes and
//               helpers for the multi-cycle divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic c_div_result_ready     = 1'b1;
  localparam logic c_div_result_not_ready = 1'b0;
  localparam logic c_div_start            = 1'b1;
  localparam logic c_div_stop             = 1'b0;

  localparam logic [7:0] c_exe_div_op  = 8'b00011010;
  localparam logic [7:0] c_exe_divu_op = 8'b00011011;

  // States in which a pipeline flush may still cancel the operation.
  function automatic logic div_busy(input div_state_e state);
    return (state == DIV_ON) || (state == DIV_BYZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration on {rem,quo}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] partial,
  input  logic [WIDTH-1:0]   divisor_mag,
  output logic [2*WIDTH-1:0] partial_next
);

  logic [WIDTH:0] w_trial;

  // The upper WIDTH+1 bits of the shifted pair are partial[2W-1:W-1].
  assign w_trial = partial[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_mag};

  always_comb begin
    partial_next = {partial[2*WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      partial_next = {w_trial[WIDTH-1:0], partial[WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle signed/unsigned restoring divider, one quotient
//               bit per clock; result = {remainder, quotient}.
//               Optional: DIV_BYZERO_FLAG_EN adds the dbz output.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
`ifdef DIV_BYZERO_FLAG_EN
  ,
  output logic               dbz
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_divisor;
  logic [WIDTH-1:0]    r_dividend;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*WIDTH-1:0]  r_result;
  logic                r_ready;

  logic [WIDTH-1:0]    w_op1_mag;
  logic [WIDTH-1:0]    w_op2_mag;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]    w_quo;
  logic [WIDTH-1:0]    w_rem;
  logic [WIDTH-1:0]    w_quo_fix;
  logic [WIDTH-1:0]    w_rem_fix;

  assign w_op1_mag = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign w_op2_mag = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  assign w_quo = r_acc[WIDTH-1:0];
  assign w_rem = r_acc[2*WIDTH-1:WIDTH];

  // MIN / -1 falls out naturally: |MIN| = MIN and its negation wraps to MIN.
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .partial      (r_acc),
    .divisor_mag  (r_divisor),
    .partial_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_ready    <= c_div_result_not_ready;
    end else if (div_busy(r_state) && annul) begin
      r_state <= DIV_FREE;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (start == c_div_start && !annul) begin
            r_dividend <= opdata1;
            r_divisor  <= w_op2_mag;
            r_acc      <= {{WIDTH{1'b0}}, w_op1_mag};
            r_neg_q    <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg_r    <= signed_div && opdata1[WIDTH-1];
            r_cnt      <= '0;
            r_state    <= (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: begin
          r_result <= {r_dividend, {WIDTH{1'b1}}};
          r_ready  <= c_div_result_ready;
          r_state  <= DIV_END;
        end
        DIV_ON: begin
          if (r_cnt == c_cnt_last) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= c_div_result_ready;
            r_state  <= DIV_END;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        DIV_END: begin
          if (start == c_div_stop) begin
            r_ready <= c_div_result_not_ready;
            r_state <= DIV_FREE;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

  assign result = r_result;
  assign ready  = r_ready;

`ifdef DIV_BYZERO_FLAG_EN
  logic r_dbz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbz <= 1'b0;
    end else if (r_state == DIV_BYZERO && !annul) begin
      r_dbz <= 1'b1;
    end else if (r_state == DIV_END && start == c_div_stop) begin
      r_dbz <= 1'b0;
    end
  end

  assign dbz = r_dbz;
`endif

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle restoring divider for the EX stage; successor to the fixed single-cycle ALU path.
- Divides two WIDTH-bit operands, signed or unsigned, at one quotient bit per clock.
- Returns {remainder, quotient} for writing into HI/LO.
- EX holds start high and raises stallreq to ctrl until ready; a flush cancels the operation via annul.

Parameters:
WIDTH, 32, operand width in bits; any value 4..64.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; held high by EX until ready is seen
annul  in  1  cancel the in-flight operation (pipeline flush)
signed_div  in  1  1 = two's-complement divide, 0 = unsigned
opdata1  in  WIDTH  dividend
opdata2  in  WIDTH  divisor
result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
ready  out  1  result valid

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, result=0, ready=0, counter=0, internal registers=0. Reset applies immediately mid-operation; no partial result survives.
- States: FREE, BYZERO, ON, END (encodings in defines.v).
- FREE:
  - start=1 and annul=0: latch operands and signed_div.
  - Divisor==0: go to BYZERO.
  - Otherwise go to ON, with cnt=0 and the partial remainder loaded from |dividend|.
  - Signed mode: magnitudes are the two's-complement negation of negative operands. Unsigned mode: operands are used raw.
- BYZERO: next edge go to END with result={opdata1 latched, all-ones quotient}.
- ON: each edge performs one restoring step.
  - Shift {rem,quo} left by one.
  - Trial-subtract |divisor| from the upper WIDTH+1 bits.
  - Non-negative trial: keep the difference and set quo LSB=1. Negative trial: restore the remainder and set quo LSB=0.
  - cnt increments each step. When cnt==WIDTH, apply sign correction and go to END instead of stepping.
- Sign correction (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MIN / -1 yields quotient=MIN, remainder=0 (wraps; no trap).
- END: ready=1 and result is stable. Stay in END while start=1. start=0 → FREE, ready=0 the same edge.
- Latency: ready is visible after WIDTH+2 edges counting the start-sampling edge (34 for WIDTH=32). Divide-by-zero takes 2 edges.
- annul=1 in ON or BYZERO: next edge → FREE, ready stays 0, result unchanged. annul in FREE blocks acceptance; annul in END is ignored.
- Operand or signed_div changes while busy are ignored, since values were latched at acceptance.
- start and annul high together in FREE: annul wins and nothing is accepted.
- No new operation is accepted until the FSM has returned to FREE. Back-to-back operations therefore need one idle edge (start low).

Optional Feature:
- Macro: DIV_BYZERO_FLAG_EN.
- With the macro defined:
  - Adds output dbz (1 bit), reset 0.
  - dbz=1 exactly while ready=1 for a divide-by-zero result; 0 otherwise.
- Without the macro: the port is absent and divide-by-zero is indistinguishable except by the result pattern.

Decomposition:
- defines.v: DivFree/DivByZero/DivOn/DivEnd state codes, DivResultReady/DivResultNotReady, DivStart/DivStop. The EX aluop codes for DIV/DIVU also belong there.
- Sub-module div_step: combinational, one restoring iteration, parametrised WIDTH.
  - Inputs: partial {rem,quo}, divisor magnitude.
  - Output: next {rem,quo}.
- FSM, counter and sign handling stay in div_unit.

Test Plan:
- WIDTH=32, unsigned 100/7 → quotient 14, remainder 2, ready on edge 34 and held while start=1; drop start → ready=0 next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0; unsigned same operands → quotient 0, remainder 0x80000000.
- Divisor 0, dividend 0x12345678 → result {0x12345678, 0xFFFFFFFF}, ready on edge 2; with DIV_BYZERO_FLAG_EN, dbz=1 alongside.
- annul pulsed at iteration 10 → FREE next edge, ready never rises. A following 100/7 start completes correctly.
- rst driven low mid-ON (between edges) → ready=0 and result=0 immediately; after release, WIDTH=8 instance unsigned 200/3 → quotient 66, remainder 2 on edge 10.
